// File: rtl/dense_layer_seq_pkg.sv
// Shared types and fixed-point helpers for the sequential dense layer and future layers.
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    REQ  = 2'd2,
    OUT  = 2'd3
  } dense_state_e;

  // Widest accumulator / result sat_round is expected to handle.
  localparam int unsigned SAT_ACC_W = 128;
  localparam int unsigned SAT_OUT_W = 64;

  function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
    return 2 * width + $clog2(n) + 1;
  endfunction

  // Round half toward +inf by dropping frac bits, then clamp to a signed width-bit range.
  function automatic logic signed [SAT_OUT_W-1:0] sat_round(
    input logic signed [SAT_ACC_W-1:0] acc,
    input int unsigned                 frac,
    input int unsigned                 width
  );
    logic signed [SAT_ACC_W-1:0] one;
    logic signed [SAT_ACC_W-1:0] hi;
    logic signed [SAT_ACC_W-1:0] lo;
    logic signed [SAT_ACC_W-1:0] r;
    one = SAT_ACC_W'(1);
    r   = (acc + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (width - 1)) - one;
    lo  = -(one <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return SAT_OUT_W'(r);
  endfunction

endpackage

// File: rtl/dense_layer_seq_mac_lane.sv
// One neuron: bias-initialised accumulator, multiply-accumulate, and registered requantised result.
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_init,
  input  logic signed [WIDTH-1:0] i_bias,
  input  logic                    i_mac_en,
  input  logic signed [WIDTH-1:0] i_w,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic                    i_requant,
  input  logic                    i_relu,
  output logic [WIDTH-1:0]        o_result
);

  logic signed [ACC_W-1:0]     r_acc;
  logic [WIDTH-1:0]            r_result;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_bias_acc;
  logic signed [SAT_ACC_W-1:0] w_acc_wide;
  logic signed [SAT_OUT_W-1:0] w_sat;
  logic [WIDTH-1:0]            w_result;

  assign w_prod     = i_w * i_x;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_bias_acc = ACC_W'(i_bias) <<< FRAC;

  assign w_acc_wide = SAT_ACC_W'(r_acc);
  assign w_sat      = sat_round(w_acc_wide, FRAC, WIDTH);
  assign w_result   = (i_relu && (w_sat < 0)) ? '0 : WIDTH'(w_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (i_init) begin
        r_acc <= w_bias_acc;
      end else if (i_mac_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (i_requant) begin
        r_result <= w_result;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential handshaked dense layer: M parallel neurons, one input element per cycle.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int unsigned M     = 3,
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [M-1:0][N-1:0][WIDTH-1:0]  weights,
  input  logic [M-1:0][WIDTH-1:0]         bias,
  input  logic                            relu_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0][WIDTH-1:0]         in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [M-1:0][WIDTH-1:0]         out_data
);

  localparam int unsigned    ACC_W  = acc_width(WIDTH, N);
  localparam int unsigned    K_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  dense_state_e            r_state;
  dense_state_e            w_state_nxt;
  logic [K_W-1:0]          r_k;
  logic [N-1:0][WIDTH-1:0] r_x;
  logic                    r_relu;
  logic                    w_init;
  logic                    w_mac_en;
  logic                    w_requant;
  logic [WIDTH-1:0]        w_x;

  // in_ready is gated by rst_n so it reads low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_mac_en    = 1'b0;
    w_requant   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_init      = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (r_k == K_LAST) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_requant   = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_x     <= '0;
      r_relu  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init) begin
        r_k    <= '0;
        r_x    <= in_data;
        r_relu <= relu_en;
      end else if (w_mac_en) begin
        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      end
    end
  end

  assign w_x = r_x[r_k];

  for (genvar m = 0; m < M; m++) begin : g_lane
    dense_mac_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_init   (w_init),
      .i_bias   (bias[m]),
      .i_mac_en (w_mac_en),
      .i_w      (weights[m][r_k]),
      .i_x      (w_x),
      .i_requant(w_requant),
      .i_relu   (r_relu),
      .o_result (out_data[m])
    );
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed scoreboard bench for dense_layer_seq (M=3, N=4, Q8.8).
module tb_dense_layer_seq;

  localparam int unsigned M     = 3;
  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned FRAC  = 8;

  typedef logic [M-1:0][N-1:0][WIDTH-1:0] w_t;
  typedef logic [M-1:0][WIDTH-1:0]        b_t;
  typedef logic [N-1:0][WIDTH-1:0]        x_t;
  typedef logic [M*WIDTH-1:0]             outv_t;

  logic  clk = 1'b0;
  logic  rst_n;
  w_t    weights;
  b_t    bias;
  logic  relu_en;
  logic  in_valid;
  logic  in_ready;
  x_t    in_data;
  logic  out_valid;
  logic  out_ready;
  b_t    out_data;

  int    total = 0;
  int    bad   = 0;
  outv_t sb[$];

  dense_layer_seq #(
    .M    (M),
    .N    (N),
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .weights  (weights),
    .bias     (bias),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic outv_t mkout(input int o0, input int o1, input int o2);
    return {16'(o2), 16'(o1), 16'(o0)};
  endfunction

  task automatic set_w(input int m, input int a0, input int a1, input int a2, input int a3);
    weights[m][0] = 16'(a0);
    weights[m][1] = 16'(a1);
    weights[m][2] = 16'(a2);
    weights[m][3] = 16'(a3);
  endtask

  function automatic x_t mkx(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(1023)) - 512;
  endfunction

  // Reference: exact sum, floor((acc + half) / 2^FRAC), clamp, optional ReLU.
  function automatic outv_t model(input w_t w, input b_t b, input x_t x, input bit relu);
    outv_t  r;
    longint acc;
    longint q;
    r = '0;
    for (int m = 0; m < M; m++) begin
      acc = longint'($signed(b[m])) * 256;
      for (int k = 0; k < N; k++) begin
        acc += longint'($signed(w[m][k])) * longint'($signed(x[k]));
      end
      q = acc + 128;
      if (q >= 0) q = q / 256;
      else        q = -((-q + 255) / 256);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      if (relu && q < 0) q = 0;
      r[m*WIDTH +: WIDTH] = 16'(q);
    end
    return r;
  endfunction

  // Called at a negedge with the block idle; returns at the negedge where out_valid is seen.
  task automatic send(input x_t x, input bit relu, input outv_t exp, input bit pulse);
    int cyc;
    sb.push_back(exp);
    in_data  = x;
    relu_en  = relu;
    in_valid = 1'b1;
    check("in_ready_at_send", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    relu_en  = ~relu;
    in_data  = ~x;
    check("in_ready_in_mac", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
      check("in_ready_busy", in_ready, 0);
      if (pulse && cyc == 1) begin
        in_valid = 1'b1;
        in_data  = mkx(1000, -1000, 77, 5);
      end
      if (pulse && cyc == 2) in_valid = 1'b0;
    end
    check("latency", 64'(cyc), 64'(N + 1));
  endtask

  task automatic receive(input int hold);
    outv_t e;
    b_t    snap;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int m = 0; m < M; m++) begin
      check($sformatf("out%0d", m), out_data[m], e[m*WIDTH +: WIDTH]);
    end
    snap = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", out_data, snap);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    w_t    rw;
    b_t    rb;
    x_t    rx;
    outv_t e;

    rst_n     = 1'b0;
    weights   = '0;
    bias      = '0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // Basic
    set_w(0, 256, 0, 0, 0);
    set_w(1, 128, 128, 0, 0);
    set_w(2, 0, 0, 0, -256);
    bias = '0;
    send(mkx(256, 512, 768, 1024), 1'b0, mkout(256, 384, -1024), 1'b0);
    receive(0);

    // Bias and ReLU (send toggles relu_en right after accept)
    bias = {16'(-256), 16'(0), 16'(256)};
    send(mkx(256, 512, 768, 1024), 1'b1, mkout(512, 384, 0), 1'b0);
    receive(0);

    // Rounding
    bias = '0;
    set_w(1, 0, 0, 0, 0);
    set_w(2, 0, 0, 0, 0);
    set_w(0, 128, 0, 0, 0);
    send(mkx(1, 0, 0, 0), 1'b0, mkout(1, 0, 0), 1'b0);
    receive(0);
    set_w(0, -128, 0, 0, 0);
    send(mkx(1, 0, 0, 0), 1'b0, mkout(0, 0, 0), 1'b0);
    receive(0);
    set_w(0, -129, 0, 0, 0);
    send(mkx(1, 0, 0, 0), 1'b0, mkout(-1, 0, 0), 1'b0);
    receive(0);

    // Saturation
    for (int m = 0; m < M; m++) set_w(m, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    send(mkx(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), 1'b0, mkout(32767, 32767, 32767), 1'b0);
    receive(0);
    for (int m = 0; m < M; m++) set_w(m, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
    send(mkx(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), 1'b0, mkout(-32768, -32768, -32768), 1'b0);
    receive(0);

    // Backpressure, ignored in_valid during MAC, back-to-back accept
    for (int m = 0; m < M; m++) set_w(m, rnd_val(), rnd_val(), rnd_val(), rnd_val());
    bias = {16'(rnd_val()), 16'(rnd_val()), 16'(rnd_val())};
    rx   = mkx(rnd_val(), rnd_val(), rnd_val(), rnd_val());
    e    = model(weights, bias, rx, 1'b0);
    send(rx, 1'b0, e, 1'b1);
    receive(10);
    rx = mkx(rnd_val(), rnd_val(), rnd_val(), rnd_val());
    e  = model(weights, bias, rx, 1'b1);
    send(rx, 1'b1, e, 1'b0);
    receive(2);

    // Reset mid-MAC at k=2
    rw = '0;
    for (int m = 0; m < M; m++) set_w(m, rnd_val(), rnd_val(), rnd_val(), rnd_val());
    rw = weights;
    rb = bias;
    in_data  = mkx(300, -200, 100, 50);
    relu_en  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    rx = mkx(rnd_val(), rnd_val(), rnd_val(), rnd_val());
    e  = model(rw, rb, rx, 1'b0);
    send(rx, 1'b0, e, 1'b0);
    receive(0);

    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
